// File: rtl/bus_arbiter2_pkg.sv
// ---------------------------------------------------------------------------
// bus_arbiter2_pkg
//   Shared definitions for the two-master bus arbiter:
//     - FSM state encodings (kept as plain 2-bit constants so they match the
//       values older blocks and debug scripts expect),
//     - priority-mode selectors,
//     - a helper that sizes the beat counter from MAX_HOLD.
// ---------------------------------------------------------------------------
package bus_arbiter2_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE = 2'd0;
  localparam arb_state_t ST_OWN0 = 2'd1;
  localparam arb_state_t ST_OWN1 = 2'd2;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  // Beat counter must hold the value MAX_HOLD itself; at least one bit so the
  // MAX_HOLD = 0 (forced release disabled) build still has a legal vector.
  function automatic int cnt_width(input int max_hold);
    if (max_hold < 1) begin
      return 1;
    end
    return $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/bus_arbiter2_hold_counter.sv
// ---------------------------------------------------------------------------
// hold_counter
//   Saturating count of accepted beats for the current bus owner. Used by the
//   arbiter to decide when a long burst must hand the bus to a waiting master.
//
// Ports
//   clk       in   clock, rising edge
//   reset_n   in   asynchronous active-low reset (count -> 0)
//   clr       in   clear the count (new owner / release); wins over inc
//   inc       in   one beat accepted this cycle
//   at_max    out  the count is at MAX_HOLD once this cycle's beat is included;
//                  always 0 when MAX_HOLD = 0
// ---------------------------------------------------------------------------
module hold_counter
  import bus_arbiter2_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = cnt_width(MAX_HOLD)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam bit             FORCE_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_HOLD);
  // One below the limit; pinned to 0 when the limit is disabled so the
  // constant never wraps.
  localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(FORCE_EN ? MAX_HOLD - 1 : 0);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Look-ahead: the beat being accepted now is the one that reaches the
  // limit, so the arbiter can release on this same edge. A counter already
  // saturated (other master arrived late) also qualifies.
  always_comb begin
    at_max = 1'b0;
    if (FORCE_EN) begin
      at_max = (cnt_q == MAX_C) || (inc && (cnt_q == MAX_M1));
    end
  end

endmodule

// File: rtl/bus_arbiter2.sv
// ---------------------------------------------------------------------------
// bus_arbiter2
//   Two-master arbiter for one shared bus: requester 0 is the CPU memory
//   port, requester 1 the VGA framebuffer reader. Grants are held across
//   multi-beat bursts, handed over back-to-back when the other master is
//   waiting, and optionally forced off after MAX_HOLD accepted beats.
//   The sel output steers the external busMux2_1 owned by the parent.
//
// Parameters
//   MAX_HOLD   accepted beats before forced release (0 disables)
//   PRIO_MODE  PRIO_RR: ties go to the master that did not own last
//              PRIO_FIXED: ties go to requester 1
//
// Ports
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   req0/req1  in   request; held high until the final beat is accepted
//   last0/1    in   current beat of that requester is its last
//   bus_ready  in   slave accepts the current beat
//   gnt0/gnt1  out  ownership (registered, mutually exclusive)
//   sel        out  mux select, 1 = requester 1 (registered, holds in idle)
//   bus_busy   out  gnt0 | gnt1 (registered)
//
//   state   | meaning
//   --------+----------------------------------
//   ST_IDLE | nobody owns the bus
//   ST_OWN0 | requester 0 owns the bus, sel = 0
//   ST_OWN1 | requester 1 owns the bus, sel = 1
// ---------------------------------------------------------------------------
module bus_arbiter2
  import bus_arbiter2_pkg::*;
#(
  parameter int MAX_HOLD  = 16,
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req0,
  input  logic last0,
  input  logic req1,
  input  logic last1,
  input  logic bus_ready,
  output logic gnt0,
  output logic gnt1,
  output logic sel,
  output logic bus_busy
);

  arb_state_t state_q;
  arb_state_t state_d;
  logic       last_owner_q;
  logic       last_owner_d;
  logic       gnt0_q;
  logic       gnt0_d;
  logic       gnt1_q;
  logic       gnt1_d;
  logic       sel_q;
  logic       sel_d;
  logic       bus_busy_q;
  logic       bus_busy_d;

  logic acc0;
  logic acc1;
  logic rel0;
  logic rel1;
  logic cnt_clr;
  logic at_max;

  assign acc0 = gnt0_q & req0 & bus_ready;
  assign acc1 = gnt1_q & req1 & bus_ready;

  // Release: final beat accepted, hold limit hit while the other master
  // waits, or the owner dropped its request (abort).
  assign rel0 = (acc0 & (last0 | (at_max & req1))) | ~req0;
  assign rel1 = (acc1 & (last1 | (at_max & req0))) | ~req1;

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;

    case (state_q)
      ST_IDLE: begin
        if (req0 && req1) begin
          if (PRIO_MODE == PRIO_FIXED) begin
            state_d = ST_OWN1;
          end else begin
            state_d = last_owner_q ? ST_OWN0 : ST_OWN1;
          end
        end else if (req0) begin
          state_d = ST_OWN0;
        end else if (req1) begin
          state_d = ST_OWN1;
        end
      end
      ST_OWN0: begin
        if (rel0) begin
          state_d = req1 ? ST_OWN1 : ST_IDLE;
        end
      end
      ST_OWN1: begin
        if (rel1) begin
          state_d = req0 ? ST_OWN0 : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if ((state_d == ST_OWN0) && (state_q != ST_OWN0)) begin
      last_owner_d = 1'b0;
    end else if ((state_d == ST_OWN1) && (state_q != ST_OWN1)) begin
      last_owner_d = 1'b1;
    end
  end

  // Any change of owner (grant, handover, release) restarts the beat count.
  assign cnt_clr = (state_d != state_q);

  hold_counter #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (acc0 | acc1),
    .at_max  (at_max)
  );

  // Outputs are registered from the next state so they change on the same
  // edge as the state; sel keeps its value through idle to avoid mux toggles.
  always_comb begin
    gnt0_d     = (state_d == ST_OWN0);
    gnt1_d     = (state_d == ST_OWN1);
    bus_busy_d = gnt0_d | gnt1_d;
    sel_d      = sel_q;
    if (gnt1_d) begin
      sel_d = 1'b1;
    end else if (gnt0_d) begin
      sel_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      sel_q        <= 1'b0;
      bus_busy_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      sel_q        <= sel_d;
      bus_busy_q   <= bus_busy_d;
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign sel      = sel_q;
  assign bus_busy = bus_busy_q;

endmodule

// File: tb/tb_bus_arbiter2.sv
// Bench for bus_arbiter2: three instances share one stimulus stream
//   [0] rr : MAX_HOLD=16, round-robin
//   [1] fx : MAX_HOLD=16, fixed priority
//   [2] mh : MAX_HOLD=4,  round-robin
// A per-instance ownership model (owner / beat count / last winner) is
// stepped on each rising edge and compared on every falling edge.
module tb_bus_arbiter2;

  logic clk       = 1'b0;
  logic reset_n   = 1'b1;
  logic req0      = 1'b0;
  logic last0     = 1'b0;
  logic req1      = 1'b0;
  logic last1     = 1'b0;
  logic bus_ready = 1'b0;

  logic [2:0] g0;
  logic [2:0] g1;
  logic [2:0] sl;
  logic [2:0] bb;

  int errors = 0;
  int checks = 0;

  int    mh_cfg[3] = '{16, 16, 4};
  int    fx_cfg[3] = '{0, 1, 0};
  string nm[3]     = '{"rr", "fx", "mh"};

  int owner[3] = '{-1, -1, -1};
  int beats[3] = '{0, 0, 0};
  int lastw[3] = '{1, 1, 1};
  bit msel[3]  = '{0, 0, 0};

  bus_arbiter2 #(.MAX_HOLD(16), .PRIO_MODE(0)) u_rr (
    .clk(clk), .reset_n(reset_n), .req0(req0), .last0(last0), .req1(req1),
    .last1(last1), .bus_ready(bus_ready), .gnt0(g0[0]), .gnt1(g1[0]),
    .sel(sl[0]), .bus_busy(bb[0]));

  bus_arbiter2 #(.MAX_HOLD(16), .PRIO_MODE(1)) u_fx (
    .clk(clk), .reset_n(reset_n), .req0(req0), .last0(last0), .req1(req1),
    .last1(last1), .bus_ready(bus_ready), .gnt0(g0[1]), .gnt1(g1[1]),
    .sel(sl[1]), .bus_busy(bb[1]));

  bus_arbiter2 #(.MAX_HOLD(4), .PRIO_MODE(0)) u_mh (
    .clk(clk), .reset_n(reset_n), .req0(req0), .last0(last0), .req1(req1),
    .last1(last1), .bus_ready(bus_ready), .gnt0(g0[2]), .gnt1(g1[2]),
    .sel(sl[2]), .bus_busy(bb[2]));

  always #5 clk = ~clk;

  task automatic model_step(input int k);
    bit r[2];
    bit l[2];
    int o;
    int other;
    int win;
    bit done;
    r[0] = req0; r[1] = req1; l[0] = last0; l[1] = last1;
    if (owner[k] < 0) begin
      win = -1;
      if (r[0] && r[1]) win = (fx_cfg[k] == 1) ? 1 : 1 - lastw[k];
      else if (r[0]) win = 0;
      else if (r[1]) win = 1;
      if (win >= 0) begin
        owner[k] = win; beats[k] = 0; lastw[k] = win;
      end
    end else begin
      o = owner[k]; other = 1 - o; done = 0;
      if (!r[o]) done = 1;
      else if (bus_ready) begin
        if (beats[k] < mh_cfg[k]) beats[k]++;
        if (l[o]) done = 1;
        if (mh_cfg[k] != 0 && beats[k] == mh_cfg[k] && r[other]) done = 1;
      end
      if (done) begin
        if (r[other]) begin
          owner[k] = other; beats[k] = 0; lastw[k] = other;
        end else begin
          owner[k] = -1;
        end
      end
    end
    if (owner[k] == 1) msel[k] = 1;
    else if (owner[k] == 0) msel[k] = 0;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 3; k++) begin
        owner[k] = -1; beats[k] = 0; lastw[k] = 1; msel[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) model_step(k);
    end
  end

  logic [3:0] act_v;
  logic [3:0] want_v;
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      act_v  = {g0[k], g1[k], sl[k], bb[k]};
      want_v = {owner[k] == 0, owner[k] == 1, msel[k], owner[k] >= 0};
      checks++;
      if (act_v !== want_v) begin
        errors++;
        $display("FAIL model_%s t=%0t gnt0,gnt1,sel,busy got %b want %b",
                 nm[k], $time, act_v, want_v);
      end
      checks++;
      if ((g0[k] & g1[k]) !== 1'b0) begin
        errors++;
        $display("FAIL excl_%s t=%0t gnt0=%b gnt1=%b want not both",
                 nm[k], $time, g0[k], g1[k]);
      end
      if (bb[k] === 1'b1) begin
        checks++;
        if (sl[k] !== g1[k]) begin
          errors++;
          $display("FAIL selgnt_%s t=%0t sel=%b want gnt1=%b",
                   nm[k], $time, sl[k], g1[k]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s t=%0t got %b want %b", name, $time, act, want);
    end
  endtask

  task automatic drive(input bit r0, input bit l0, input bit r1,
                       input bit l1, input bit rdy);
    req0 = r0; last0 = l0; req1 = r1; last1 = l1; bus_ready = rdy;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    // 1: reset, first grant, asynchronous reset mid-burst
    #1 reset_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_gnt0", g0[0], 1'b0);
    chk("rst_sel",  sl[0], 1'b0);
    chk("rst_busy", bb[0], 1'b0);
    reset_n = 1'b1;
    tick();
    drive(1, 0, 0, 0, 0);
    tick();
    chk("s1_gnt0", g0[0], 1'b1);
    chk("s1_sel",  sl[0], 1'b0);
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("s1_async_gnt0", g0[0], 1'b0);
    chk("s1_async_busy", bb[0], 1'b0);
    tick();
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();

    // 2: round-robin tie, 3-beat burst, back-to-back handover
    drive(1, 0, 1, 0, 1);
    tick();
    chk("s2_rr_tie_gnt0", g0[0], 1'b1);
    chk("s3_fx_tie_gnt1", g1[1], 1'b1);
    tick(); tick();
    drive(1, 1, 1, 0, 1);
    tick();
    chk("s2_handover_gnt1", g1[0], 1'b1);
    chk("s2_handover_gnt0", g0[0], 1'b0);
    chk("s2_handover_sel",  sl[0], 1'b1);
    drive(0, 0, 1, 1, 1);
    tick();
    chk("s2_idle_busy", bb[0], 1'b0);
    chk("s2_idle_sel",  sl[0], 1'b1);
    drive(0, 0, 0, 0, 0);
    tick();

    // 3: fixed priority, tie twice
    drive(1, 0, 1, 0, 1);
    tick();
    chk("s3_fx_tie1_gnt1", g1[1], 1'b1);
    drive(1, 0, 1, 1, 1);
    tick();
    chk("s3_fx_hand_gnt0", g0[1], 1'b1);
    chk("s3_fx_hand_sel",  sl[1], 1'b0);
    drive(1, 1, 0, 0, 1);
    tick();
    chk("s3_fx_idle_busy", bb[1], 1'b0);
    drive(0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 1, 0, 1);
    tick();
    chk("s3_fx_tie2_gnt1", g1[1], 1'b1);
    drive(0, 0, 0, 0, 0);
    tick(); tick();

    // 4: MAX_HOLD=4 forced release, then 10 beats uncontested
    drive(1, 0, 0, 0, 1);
    tick();
    chk("s4_mh_gnt0", g0[2], 1'b1);
    drive(1, 0, 1, 0, 1);
    tick(); tick(); tick();
    chk("s4_mh_beat3_gnt0", g0[2], 1'b1);
    tick();
    chk("s4_mh_forced_gnt0", g0[2], 1'b0);
    chk("s4_mh_forced_gnt1", g1[2], 1'b1);
    chk("s4_rr_still_gnt0",  g0[0], 1'b1);
    drive(0, 0, 0, 0, 0);
    tick(); tick();
    drive(1, 0, 0, 0, 1);
    tick();
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk($sformatf("s4_mh_beat%0d_gnt0", i), g0[2], 1'b1);
    end
    drive(1, 1, 0, 0, 1);
    tick();
    chk("s4_mh_beat10_gnt0", g0[2], 1'b0);
    chk("s4_mh_beat10_busy", bb[2], 1'b0);
    drive(0, 0, 0, 0, 0);
    tick();

    // 5: bus_ready 1,0,0,1 during a 2-beat burst
    drive(1, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 1);
    tick();
    drive(1, 1, 0, 0, 0);
    tick(); tick();
    chk("s5_stall_gnt0", g0[0], 1'b1);
    drive(1, 1, 0, 0, 1);
    tick();
    chk("s5_done_gnt0", g0[0], 1'b0);
    drive(0, 0, 0, 0, 0);
    tick();

    // 6: requester 1 aborts mid-burst
    drive(0, 0, 1, 0, 1);
    tick();
    chk("s6_gnt1", g1[0], 1'b1);
    chk("s6_sel",  sl[0], 1'b1);
    tick();
    drive(0, 0, 0, 0, 1);
    tick();
    chk("s6_abort_gnt1", g1[0], 1'b0);
    chk("s6_abort_sel",  sl[0], 1'b1);
    chk("s6_abort_busy", bb[0], 1'b0);
    tick();
    chk("s6_idle_sel", sl[0], 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
